rd53_weight_accum: RTL and testbench

Frame-level accumulator placed directly downstream of the combinational rd53 weight counter. Each cycle it can accept one 3-bit weight (0..5, the number of ones in a 5-bit input word) over a valid/ready handshake. It sums the weights and counts the words until the word marked last, then holds the frame total, word count and status flags until the consumer accepts them. It turns per-word popcounts into per-frame popcounts for the fitness/statistics logic.

---
 rtl/rd53_weight_accum.sv | 79 +++++++
 tb/tb_rd53_weight_accum.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rd53_weight_accum.sv
// rd53_weight_accum: per-frame sum/count of rd53 word weights over valid/ready handshakes.
// Define WEIGHT_ACCUM_SAT_EN to saturate the frame sum instead of wrapping.
module rd53_weight_accum #(
    parameter int SUM_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_weight,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d, sum_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic             accept, illegal, carry;
    logic [SUM_W:0]   add;
    assign in_ready  = state_q != S_HOLD;
    assign out_valid = state_q == S_HOLD;
    assign accept    = in_valid & in_ready;
    assign illegal   = in_weight[2] & in_weight[1];
    assign add       = {1'b0, sum_q} + (illegal ? '0 : {{(SUM_W-2){1'b0}}, in_weight});
    assign carry     = add[SUM_W];
`ifdef WEIGHT_ACCUM_SAT_EN
    assign sum_nxt   = carry ? '1 : add[SUM_W-1:0];
`else
    assign sum_nxt   = add[SUM_W-1:0];
`endif
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (accept) begin
            state_d = in_last ? S_HOLD : S_ACCUM;
            sum_d   = sum_nxt;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d   = ovf_q | carry;
            err_d   = err_q | illegal;
        end else if (out_valid && out_ready) begin
            state_d = S_IDLE;
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end
    assign out_sum   = sum_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign out_err   = err_q;
endmodule

// File: tb/tb_rd53_weight_accum.sv
// tb_rd53_weight_accum: vector table, directed corner sequences and random frames vs a frame model.
module tb_rd53_weight_accum;
    logic       clk = 0, rst = 1;
    logic [2:0] in_weight = 0;
    logic       in_valid = 0, in_last = 0, out_ready = 0;
    logic       in_ready, out_valid, out_ovf, out_err;
    logic [7:0] out_sum, out_count;
    int tests = 0, failed = 0;
    int wq[$];

    typedef struct {
        int n;
        int w[6];
        int s;
        int c;
        int o;
        int e;
    } vec_t;
    vec_t tbl[6];

    rd53_weight_accum #(.SUM_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_weight(in_weight), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_ovf(out_ovf), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int w, input bit last);
        int k = 0;
        in_valid = 1; in_weight = 3'(w); in_last = last;
        while (!in_ready && k < 50) begin tick(); k++; end
        if (!in_ready) begin
            tests++; failed++;
            $display("FAIL ready_timeout: in_ready stuck at 0 for %0d cycles", k);
        end
        tick();
        in_valid = 0; in_last = 0;
    endtask

    task automatic play_frame(input bit gaps);
        for (int i = 0; i < wq.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_word(wq[i], i == wq.size() - 1);
        end
        chk("latency_valid", int'(out_valid), 1);
        chk("hold_in_ready", int'(in_ready), 0);
    endtask

    task automatic finish_result(input string name, input int s, input int c, input int o,
                                 input int e, input int delay);
        chk({name, "_sum"}, int'(out_sum), s);
        chk({name, "_count"}, int'(out_count), c);
        chk({name, "_ovf"}, int'(out_ovf), o);
        chk({name, "_err"}, int'(out_err), e);
        repeat (delay) begin
            tick();
            chk({name, "_stall_valid"}, int'(out_valid), 1);
            chk({name, "_stall_sum"}, int'(out_sum), s);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk({name, "_release_valid"}, int'(out_valid), 0);
        chk({name, "_release_ready"}, int'(in_ready), 1);
        chk({name, "_clear_sum"}, int'(out_sum), 0);
        chk({name, "_clear_count"}, int'(out_count), 0);
    endtask

    initial begin
        tbl[0] = '{n: 3, w: '{5, 3, 0, 0, 0, 0}, s: 8,  c: 3, o: 0, e: 0};
        tbl[1] = '{n: 1, w: '{2, 0, 0, 0, 0, 0}, s: 2,  c: 1, o: 0, e: 0};
        tbl[2] = '{n: 3, w: '{4, 7, 1, 0, 0, 0}, s: 5,  c: 3, o: 0, e: 1};
        tbl[3] = '{n: 1, w: '{1, 0, 0, 0, 0, 0}, s: 1,  c: 1, o: 0, e: 0};
        tbl[4] = '{n: 2, w: '{6, 0, 0, 0, 0, 0}, s: 0,  c: 2, o: 0, e: 1};
        tbl[5] = '{n: 6, w: '{5, 5, 5, 5, 4, 1}, s: 25, c: 6, o: 0, e: 0};

        repeat (3) tick();
        rst = 0;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        chk("rst_err", int'(out_err), 0);

        foreach (tbl[t]) begin
            wq.delete();
            for (int i = 0; i < tbl[t].n; i++) wq.push_back(tbl[t].w[i]);
            play_frame(0);
            finish_result($sformatf("vec%0d", t), tbl[t].s, tbl[t].c, tbl[t].o, tbl[t].e, 0);
        end

        // held word must wait through a stalled HOLD, then be accepted after the handshake
        wq.delete(); wq.push_back(2);
        play_frame(0);
        in_valid = 1; in_weight = 3'd4; in_last = 0;
        repeat (4) begin
            tick();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_sum", int'(out_sum), 2);
            chk("bp_count", int'(out_count), 1);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_idle_ready", int'(in_ready), 1);
        chk("bp_idle_valid", int'(out_valid), 0);
        tick();
        in_valid = 0;
        chk("bp_taken_sum", int'(out_sum), 4);
        chk("bp_taken_count", int'(out_count), 1);
        send_word(1, 1);
        finish_result("bp_frame", 5, 2, 0, 0, 0);

        wq.delete();
        repeat (52) wq.push_back(5);
        play_frame(0);
`ifdef WEIGHT_ACCUM_SAT_EN
        finish_result("ovf52", 255, 52, 1, 0, 0);
`else
        finish_result("ovf52", 4, 52, 1, 0, 0);
`endif

        wq.delete();
        repeat (260) wq.push_back(0);
        play_frame(0);
        finish_result("cnt_sat", 0, 255, 0, 0, 0);

        // partial frame plus an accept coincident with rst are both discarded
        send_word(3, 0);
        send_word(3, 0);
        in_valid = 1; in_weight = 3'd3; rst = 1;
        tick();
        rst = 0; in_valid = 0;
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_sum", int'(out_sum), 0);
        chk("mid_rst_count", int'(out_count), 0);
        send_word(1, 1);
        finish_result("post_rst", 1, 1, 0, 0, 0);

        for (int f = 0; f < 40; f++) begin
            int total, n, err, es;
            n = $urandom_range(1, 80);
            total = 0; err = 0;
            wq.delete();
            for (int i = 0; i < n; i++) begin
                int w = $urandom_range(0, 7);
                wq.push_back(w);
                if (w >= 6) err = 1; else total += w;
            end
`ifdef WEIGHT_ACCUM_SAT_EN
            es = total > 255 ? 255 : total;
`else
            es = total % 256;
`endif
            play_frame(1);
            finish_result($sformatf("rnd%0d", f), es, n, total > 255 ? 1 : 0, err,
                          $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
